// File: rtl/sync_fifo_fwft_if.sv
// sync_fifo_fwft_if: FIFO write/read/flush handshake bundle shared by the FIFO and its user.
// overflow/underflow exist only when SYNC_FIFO_ERR_FLAGS_EN is defined.
interface sync_fifo_fwft_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH_WIDTH = 8
);
  logic                  flush;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  write;
  logic                  wfull;
  logic                  walmost_full;
  logic                  read;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rempty;
  logic                  ralmost_empty;
  logic [DEPTH_WIDTH:0]  level;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic                  overflow;
  logic                  underflow;
  modport slave (
    input  flush, wdata, write, read,
    output wfull, walmost_full, rdata, rempty, ralmost_empty, level, overflow, underflow
  );
  modport master (
    output flush, wdata, write, read,
    input  wfull, walmost_full, rdata, rempty, ralmost_empty, level, overflow, underflow
  );
`else
  modport slave (
    input  flush, wdata, write, read,
    output wfull, walmost_full, rdata, rempty, ralmost_empty, level
  );
  modport master (
    output flush, wdata, write, read,
    input  wfull, walmost_full, rdata, rempty, ralmost_empty, level
  );
`endif
endinterface

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: single-clock FIFO with standard or first-word-fall-through read, level and almost flags.
// Define SYNC_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module sync_fifo_fwft #(
  parameter int DATA_WIDTH             = 8,
  parameter int DEPTH_WIDTH            = 8,
  parameter int ALMOST_FULL_THRESHOLD  = 255,
  parameter int ALMOST_EMPTY_THRESHOLD = 0,
  parameter int FWFT                   = 0
) (
  input logic             clk,
  input logic             rst_n,
  sync_fifo_fwft_if.slave bus
);
  localparam logic [DEPTH_WIDTH:0] DEPTH = {1'b1, {DEPTH_WIDTH{1'b0}}};
  localparam logic [DEPTH_WIDTH:0] AF_TH = ALMOST_FULL_THRESHOLD[DEPTH_WIDTH:0];
  localparam logic [DEPTH_WIDTH:0] AE_TH = ALMOST_EMPTY_THRESHOLD[DEPTH_WIDTH:0];
  logic [DATA_WIDTH-1:0] r_mem [0:(1<<DEPTH_WIDTH)-1];
  logic [DEPTH_WIDTH:0]  r_wptr, r_rptr, r_level;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_rempty, r_wfull, r_afull, r_aempty;
  logic                  w_wr, w_rd, w_ram_ne, w_load, w_rempty_nxt;
  logic [DEPTH_WIDTH:0]  w_level_nxt;
  assign w_wr     = bus.write & ~r_wfull & ~bus.flush;
  assign w_rd     = bus.read & ~r_rempty & ~bus.flush;
  assign w_ram_ne = r_wptr != r_rptr;
  // In FWFT mode the registered RAM read is the head register: refill it whenever it is free or being popped.
  assign w_load = (FWFT != 0) ? w_ram_ne & (r_rempty | w_rd) : w_rd;
  assign w_level_nxt = (w_wr & ~w_rd) ? r_level + 1'b1 :
                       (w_rd & ~w_wr) ? r_level - 1'b1 : r_level;
  assign w_rempty_nxt = (FWFT != 0) ? ~w_load & (r_rempty | w_rd) : (w_level_nxt == '0);
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wptr[DEPTH_WIDTH-1:0]] <= bus.wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_level  <= '0;
      r_rdata  <= '0;
      r_rempty <= 1'b1;
      r_aempty <= 1'b1;
      r_wfull  <= 1'b0;
      r_afull  <= 1'b0;
    end else if (bus.flush) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_level  <= '0;
      r_rdata  <= '0;
      r_rempty <= 1'b1;
      r_aempty <= 1'b1;
      r_wfull  <= 1'b0;
      r_afull  <= 1'b0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_load) r_rptr <= r_rptr + 1'b1;
      if (w_load) r_rdata <= r_mem[r_rptr[DEPTH_WIDTH-1:0]];
      r_level  <= w_level_nxt;
      r_rempty <= w_rempty_nxt;
      r_aempty <= w_level_nxt <= AE_TH;
      r_wfull  <= w_level_nxt == DEPTH;
      r_afull  <= w_level_nxt > AF_TH;
    end
  assign bus.rdata         = r_rdata;
  assign bus.rempty        = r_rempty;
  assign bus.ralmost_empty = r_aempty;
  assign bus.wfull         = r_wfull;
  assign bus.walmost_full  = r_afull;
  assign bus.level         = r_level;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic r_overflow, r_underflow;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (bus.flush) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= r_overflow | (bus.write & r_wfull);
      r_underflow <= r_underflow | (bus.read & r_rempty);
    end
  assign bus.overflow  = r_overflow;
  assign bus.underflow = r_underflow;
`endif
endmodule
